// File: rtl/difftest_pkg.sv
// Shared types and widths for the difftest performance-event loggers.
// log_rec_t is the payload carried from an event logger to the collector.
package difftest_pkg;

  localparam int TOTAL_W    = 64;
  localparam int ID_W       = 16;
  localparam int REC_CORE_W = 8;

  typedef struct packed {
    logic [REC_CORE_W-1:0] coreid;
    logic [ID_W-1:0]       id;
    logic [TOTAL_W-1:0]    total;
    logic [TOTAL_W-1:0]    delta;
    logic [TOTAL_W-1:0]    cycle;
  } log_rec_t;

endpackage

// File: rtl/difftest_log_event_if.sv
// Record port between one event logger (master) and the log collector (slave).
// Plain valid/ready handshake with a sticky overrun flag beside it.
interface difftest_log_event_if
  import difftest_pkg::*;
#(
  parameter int CORE_W = 8
);

  logic                rec_valid;
  logic                rec_ready;
  logic [CORE_W-1:0]   rec_coreid;
  logic [ID_W-1:0]     rec_id;
  logic [TOTAL_W-1:0]  rec_total;
  logic [TOTAL_W-1:0]  rec_delta;
  logic [TOTAL_W-1:0]  rec_cycle;
  logic                rec_overrun;

  modport master (
    output rec_valid, rec_coreid, rec_id, rec_total, rec_delta, rec_cycle, rec_overrun,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_coreid, rec_id, rec_total, rec_delta, rec_cycle, rec_overrun,
    output rec_ready
  );

endinterface

// File: rtl/log_rec_slot.sv
// Single-entry valid/ready holding register for log records.
// A load while a stalled record is still held is dropped and flagged as overrun.
module log_rec_slot
  import difftest_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load_i,
  input  log_rec_t rec_i,
  input  logic     ready_i,
  output logic     valid_o,
  output logic     accept_o,
  output logic     overrun_o,
  output log_rec_t rec_o
);

  logic     valid_q, valid_d;
  logic     overrun_q, overrun_d;
  log_rec_t rec_q, rec_d;
  logic     canLoad;
  logic     doLoad;

  // The slot frees up in the same cycle it is accepted, so a load can replace it directly.
  always_comb begin
    accept_o  = valid_q && ready_i;
    canLoad   = !valid_q || ready_i;
    doLoad    = load_i && canLoad;
    valid_d   = valid_q;
    rec_d     = rec_q;
    overrun_d = overrun_q;
    if (doLoad) begin
      valid_d = 1'b1;
      rec_d   = rec_i;
    end else if (accept_o) begin
      valid_d = 1'b0;
    end
    if (load_i && !canLoad) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      rec_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      rec_q     <= rec_d;
    end
  end

  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
  assign rec_o     = rec_q;

endmodule

// File: rtl/difftest_log_event.sv
// Per-event performance logger: accumulates increments of one free-running counter
// and emits periodic or flushed records with the running total and delta.
module difftest_log_event
  import difftest_pkg::*;
#(
  parameter logic [ID_W-1:0] EVENT_ID = '0,
  parameter int              VALUE_W  = 32,
  parameter int              CORE_W   = 8,
  parameter int              PERIOD   = 1024
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CORE_W-1:0]   coreid_i,
  input  logic [VALUE_W-1:0]  value_i,
  input  logic                en_i,
  input  logic                flush_i,
  difftest_log_event_if.master rec_o
);

  localparam int              CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);

  logic [VALUE_W-1:0] prev_q;
  logic [VALUE_W-1:0] deltaNow;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [TOTAL_W-1:0] lastTotal_q, lastTotal_d;
  logic [TOTAL_W-1:0] cyc_q;
  logic [CNT_W-1:0]   periodCnt_q, periodCnt_d;
  logic               trigger;
  logic               slotValid;
  logic               slotAccept;
  logic               slotOverrun;
  log_rec_t           slotIn, slotOut;

  // Modular subtraction absorbs counter wrap; a record accepted this cycle becomes
  // the delta base immediately so a back-to-back record spans exactly its own gap.
  always_comb begin
    deltaNow      = value_i - prev_q;
    total_d       = en_i ? total_q + TOTAL_W'(deltaNow) : total_q;
    trigger       = (periodCnt_q == LAST_CNT) || flush_i;
    periodCnt_d   = (periodCnt_q == LAST_CNT) ? '0 : periodCnt_q + 1'b1;
    lastTotal_d   = slotAccept ? slotOut.total : lastTotal_q;
    slotIn        = '0;
    slotIn.coreid = REC_CORE_W'(coreid_i);
    slotIn.id     = EVENT_ID;
    slotIn.total  = total_d;
    slotIn.delta  = total_d - lastTotal_d;
    slotIn.cycle  = cyc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      total_q     <= '0;
      lastTotal_q <= '0;
      cyc_q       <= '0;
      periodCnt_q <= '0;
    end else begin
      prev_q      <= value_i;
      total_q     <= total_d;
      lastTotal_q <= lastTotal_d;
      cyc_q       <= cyc_q + 64'd1;
      periodCnt_q <= periodCnt_d;
    end
  end

  log_rec_slot u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (trigger),
    .rec_i     (slotIn),
    .ready_i   (rec_o.rec_ready),
    .valid_o   (slotValid),
    .accept_o  (slotAccept),
    .overrun_o (slotOverrun),
    .rec_o     (slotOut)
  );

  assign rec_o.rec_valid   = slotValid;
  assign rec_o.rec_coreid  = CORE_W'(slotOut.coreid);
  assign rec_o.rec_id      = slotOut.id;
  assign rec_o.rec_total   = slotOut.total;
  assign rec_o.rec_delta   = slotOut.delta;
  assign rec_o.rec_cycle   = slotOut.cycle;
  assign rec_o.rec_overrun = slotOverrun;

endmodule

// File: tb/tb_difftest_log_event.sv
// Directed bench for difftest_log_event with PERIOD=4; expected record values are
// hand-computed per step. Accepted records are printed in the collector log format.
module tb_difftest_log_event;

  localparam string       NAME     = "event";
  localparam logic [15:0] EVENT_ID = 16'hABCD;

  logic        clk;
  logic        rst_n;
  logic [7:0]  coreid;
  logic [31:0] value;
  logic        en;
  logic        flush;

  int compared   = 0;
  int mismatched = 0;

  difftest_log_event_if #(.CORE_W(8)) recIf ();

  difftest_log_event #(
    .EVENT_ID (EVENT_ID),
    .VALUE_W  (32),
    .CORE_W   (8),
    .PERIOD   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .coreid_i (coreid),
    .value_i  (value),
    .en_i     (en),
    .flush_i  (flush),
    .rec_o    (recIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && recIf.rec_valid && recIf.rec_ready)
      $display("[TB] [%0d] %s core=%0d total=%0d delta=%0d",
               recIf.rec_cycle, NAME, recIf.rec_coreid, recIf.rec_total, recIf.rec_delta);
  end

  task automatic applyStimulus(input logic [31:0] v);
    value = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic checkRec(input string tag, input logic [63:0] total, input logic [63:0] delta,
                          input logic [63:0] cycle);
    checkOutput({tag, "_valid"}, 64'(recIf.rec_valid), 64'd1);
    checkOutput({tag, "_total"}, recIf.rec_total, total);
    checkOutput({tag, "_delta"}, recIf.rec_delta, delta);
    checkOutput({tag, "_cycle"}, recIf.rec_cycle, cycle);
  endtask

  initial begin
    rst_n           = 1'b1;
    coreid          = 8'h5A;
    value           = '0;
    en              = 1'b1;
    flush           = 1'b0;
    recIf.rec_ready = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    checkOutput("reset_valid",   64'(recIf.rec_valid),   64'd0);
    checkOutput("reset_total",   recIf.rec_total,        64'd0);
    checkOutput("reset_overrun", 64'(recIf.rec_overrun), 64'd0);
    rst_n = 1'b1;

    // Ramp +1 per cycle: records at cycles 3 and 7.
    for (int k = 0; k < 3; k++) applyStimulus(32'(k));
    checkOutput("ramp_idle", 64'(recIf.rec_valid), 64'd0);
    applyStimulus(32'd3);
    checkRec("rec1", 64'd3, 64'd3, 64'd3);
    checkOutput("rec1_coreid", 64'(recIf.rec_coreid), 64'h5A);
    checkOutput("rec1_id",     64'(recIf.rec_id),     64'(EVENT_ID));
    applyStimulus(32'd4);
    checkOutput("rec1_pulse", 64'(recIf.rec_valid), 64'd0);
    for (int k = 5; k < 8; k++) applyStimulus(32'(k));
    checkRec("rec2", 64'd7, 64'd4, 64'd7);

    // Wrap: prev jumps to FFFF_FFFE without counting, then 1 adds 3.
    en = 1'b0;
    applyStimulus(32'hFFFF_FFFE);
    en = 1'b1;
    applyStimulus(32'd1);
    applyStimulus(32'd2);
    applyStimulus(32'd3);
    checkRec("wrap", 64'd12, 64'd5, 64'd11);

    // Stall across the cycle-19 trigger; accept+load together at cycle 23.
    for (int k = 12; k < 16; k++) applyStimulus(32'(k - 8));
    checkRec("pre_stall", 64'd16, 64'd4, 64'd15);
    recIf.rec_ready = 1'b0;
    for (int k = 16; k < 19; k++) applyStimulus(32'(k - 8));
    checkOutput("stall_no_overrun", 64'(recIf.rec_overrun), 64'd0);
    applyStimulus(32'd11);
    checkRec("stall_hold", 64'd16, 64'd4, 64'd15);
    checkOutput("stall_overrun", 64'(recIf.rec_overrun), 64'd1);
    for (int k = 20; k < 23; k++) applyStimulus(32'(k - 8));
    recIf.rec_ready = 1'b1;
    applyStimulus(32'd15);
    checkRec("post_stall", 64'd24, 64'd8, 64'd23);

    // Flush at period_cnt=1 with +2 per cycle; periodic trigger still at cycle 27.
    applyStimulus(32'd17);
    checkOutput("flush_idle", 64'(recIf.rec_valid), 64'd0);
    coreid = 8'h3C;
    flush  = 1'b1;
    applyStimulus(32'd19);
    checkRec("flush", 64'd28, 64'd4, 64'd25);
    checkOutput("flush_coreid", 64'(recIf.rec_coreid), 64'h3C);
    flush  = 1'b0;
    coreid = 8'h5A;
    applyStimulus(32'd21);
    checkOutput("flush_accepted", 64'(recIf.rec_valid), 64'd0);
    applyStimulus(32'd23);
    checkRec("flush_period", 64'd32, 64'd4, 64'd27);

    // en=0 for five cycles while value rises by 5.
    en = 1'b0;
    for (int k = 28; k < 32; k++) applyStimulus(32'(k - 4));
    checkRec("en_off", 64'd32, 64'd0, 64'd31);
    applyStimulus(32'd28);
    en = 1'b1;
    for (int k = 33; k < 36; k++) applyStimulus(32'(k - 4));
    checkRec("en_on", 64'd35, 64'd3, 64'd35);

    // Flush coinciding with the period trigger gives a single record.
    for (int k = 36; k < 39; k++) applyStimulus(32'(k - 4));
    flush = 1'b1;
    applyStimulus(32'd35);
    flush = 1'b0;
    checkRec("flush_coincide", 64'd39, 64'd4, 64'd39);
    applyStimulus(32'd36);
    checkOutput("flush_single", 64'(recIf.rec_valid), 64'd0);

    // Async reset while a record is pending.
    recIf.rec_ready = 1'b0;
    for (int k = 41; k < 44; k++) applyStimulus(32'(k - 4));
    checkRec("pre_reset", 64'd43, 64'd4, 64'd43);
    checkOutput("overrun_sticky", 64'(recIf.rec_overrun), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_valid",   64'(recIf.rec_valid),   64'd0);
    checkOutput("areset_total",   recIf.rec_total,        64'd0);
    checkOutput("areset_delta",   recIf.rec_delta,        64'd0);
    checkOutput("areset_cycle",   recIf.rec_cycle,        64'd0);
    checkOutput("areset_coreid",  64'(recIf.rec_coreid),  64'd0);
    checkOutput("areset_id",      64'(recIf.rec_id),      64'd0);
    checkOutput("areset_overrun", 64'(recIf.rec_overrun), 64'd0);
    #2 rst_n = 1'b1;
    recIf.rec_ready = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(32'(k));
    checkRec("restart", 64'd3, 64'd3, 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/difftest_log_event.md
Name: difftest_log_event

Overview:
- Per-event performance logger attached to one free-running 32-bit perf counter (one instance per `PERF` event).
- Every cycle it samples the counter, accumulates the modular increment into a 64-bit total, and periodically (or on flush) emits a log record over a valid/ready port toward the difftest/log collector.
- Also prints each accepted record in simulation.

Parameters:
- NAME, "event", string event name; used only in the simulation print.
- EVENT_ID, 16'h0, numeric tag copied into each record.
- VALUE_W, 32, width of the sampled counter.
- CORE_W, 8, width of coreid.
- PERIOD, 1024, cycles between automatic records; must be ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- coreid  in  CORE_W  hart index; registered into each record.
- value  in  VALUE_W  current perf-counter value.
- en  in  1  accumulation enable.
- flush  in  1  request an immediate record.
- rec_valid  out  1  record available.
- rec_ready  in  1  collector accepts the record.
- rec_coreid  out  CORE_W  core of the record.
- rec_id  out  16  EVENT_ID.
- rec_total  out  64  accumulated event count.
- rec_delta  out  64  events since the previous accepted record.
- rec_cycle  out  64  cycle stamp of the trigger.
- rec_overrun  out  1  sticky: a trigger arrived while a record was pending.

Behaviour:
- Reset (rst=0, async) clears all state and every output to 0:
  - prev, total, last_total, cyc, period_cnt, pending record, overrun.
- cyc increments by 1 every cycle out of reset.
- Accumulation:
  - delta_now = value − prev, computed modulo 2^VALUE_W, so counter wrap is handled.
  - prev <= value every cycle, regardless of en.
  - If en=1: total <= total + zero-extended delta_now. If en=0: total holds, and the skipped increment is lost.
- period_cnt counts 0..PERIOD−1 and wraps. trigger = (period_cnt == PERIOD−1) || flush.
- Trigger while the output is idle (rec_valid=0, or rec_valid=1 with rec_ready=1 the same cycle). Next cycle:
  - rec_valid=1.
  - rec_total = total including this cycle's increment.
  - rec_delta = that total − last_total.
  - rec_cycle = cyc at the trigger cycle; rec_coreid = coreid sampled that cycle.
  - Latency: 1 cycle.
- Handshake:
  - Record fields hold stable while rec_valid && !rec_ready.
  - On acceptance (valid && ready), last_total <= rec_total and rec_valid drops unless a new trigger loads the next record in the same cycle.
- Trigger while a record is stalled:
  - Trigger is dropped and rec_overrun set.
  - No counts are lost; the next record's delta spans the gap.
  - rec_overrun clears only on reset.
- flush coinciding with the period trigger yields one record. period_cnt is not restarted by flush.
- Simulation only (not synthesized): on acceptance, print "[cycle] NAME core=X total=T delta=D".

Decomposition:
- Shared package difftest_pkg holds:
  - log_rec_t struct (coreid, id, total, delta, cycle);
  - TOTAL_W=64, ID_W=16 constants.
- One natural sub-module, log_rec_slot: a single-entry valid/ready holding register (load, accept, stall, overrun detection).
- Accumulator and period counter stay in the top.

Test Plan:
- Reset release, value ramps 0,1,2,… with en=1, PERIOD=4, rec_ready=1. Expected:
  - rec_valid pulses every 4 cycles.
  - First record total=3 (value at the trigger), delta=3, cycle=3.
  - Second record total=7, delta=4.
- Wrap: prev=32'hFFFF_FFFE, next value=32'h0000_0001. Expected: total advances by 3.
- Stall: rec_ready=0 across two period triggers. Expected:
  - Fields stable; rec_overrun=1.
  - After ready rises, the next record's delta covers both periods (8 with PERIOD=4 and +1/cycle).
- flush mid-period (period_cnt=1) with value rising by 2/cycle. Expected:
  - Record one cycle later with delta equal to the increments so far.
  - Periodic trigger still fires at period_cnt=3.
- en=0 for 5 cycles while value rises by 5. Expected: total unchanged; prev tracks value, so no burst when en returns.
- Async reset mid-record: rst low between clock edges. Expected: rec_valid and all outputs 0 immediately; cyc restarts at 0.
